// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax input server.
//   - default geometry (element width, elements per word, word address width)
//   - fp16 pad constants used to fill the unused lanes of a partial last word
//   - load/handshake FSM state encoding
package softmax_pkg;

    localparam int unsigned DATAWIDTH_DEF = 16;
    localparam int unsigned NUM_DEF       = 8;
    localparam int unsigned ADDRSIZE_DEF  = 7;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        INIT  = 3'd3,
        START = 3'd4,
        WAIT  = 3'd5
    } state_e;

endpackage

// File: rtl/softmax_rd_bank.sv
// One replicated read bank: single write port, single registered read port.
// Read-before-write on an address collision (the read sees the old word).
// Ports:
//   clk, reset   clock, async active-low reset (clears only the read register)
//   we_i         write enable
//   waddr_i      write word address
//   wdata_i      write word
//   raddr_i      read word address, sampled every edge
//   rdata_o      word at raddr_i as sampled on the previous edge
module softmax_rd_bank
    import softmax_pkg::*;
#(
    parameter int unsigned WIDTH    = DATAWIDTH_DEF * NUM_DEF,
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we_i,
    input  logic [ADDRSIZE-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic [ADDRSIZE-1:0] raddr_i,
    output logic [WIDTH-1:0]    rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/softmax_inp_server.sv
// Memory-side responder for the softmax engine's three read ports.
// Packs a stream of fp16 elements NUM per word, writes each word into three
// identical read banks, then drives init/start to the softmax engine and
// holds off new input until softmax signals done.
//
// Build option: SOFTMAX_PAD_NEGINF_EN
//   defined   -> unfilled lanes of a partial last word are fp16 -inf
//   undefined -> unfilled lanes are +0.0
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   in_valid/in_ready          element stream handshake
//   in_data, in_last           element and end-of-vector marker
//   addr, sub0_inp_addr,
//   sub1_inp_addr              softmax read addresses
//   inp, sub0_inp, sub1_inp    read data, one cycle after the address
//   start_addr, end_addr       first / last valid word of the stored vector
//   init, start                one-cycle control pulses to softmax
//   done                       softmax completion
//   busy                       vector in flight (first element until done)
//   overflow                   sticky: vector truncated at memory full
module softmax_inp_server
    import softmax_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned NUM       = NUM_DEF,
    parameter int unsigned ADDRSIZE  = ADDRSIZE_DEF,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATAWIDTH-1:0]     in_data,
    input  logic                     in_last,
    input  logic [ADDRSIZE-1:0]      addr,
    input  logic [ADDRSIZE-1:0]      sub0_inp_addr,
    input  logic [ADDRSIZE-1:0]      sub1_inp_addr,
    output logic [DATAWIDTH*NUM-1:0] inp,
    output logic [DATAWIDTH*NUM-1:0] sub0_inp,
    output logic [DATAWIDTH*NUM-1:0] sub1_inp,
    output logic [ADDRSIZE-1:0]      start_addr,
    output logic [ADDRSIZE-1:0]      end_addr,
    output logic                     init,
    output logic                     start,
    input  logic                     done,
    output logic                     busy,
    output logic                     overflow
);

    localparam int unsigned WORD_W = DATAWIDTH * NUM;
    localparam int unsigned LANE_W = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(NUM - 1);
    localparam logic [ADDRSIZE-1:0] LAST_ADDR = '1;
    localparam logic [ADDRSIZE-1:0] BASE      = ADDRSIZE'(BASE_ADDR);

`ifdef SOFTMAX_PAD_NEGINF_EN
    localparam logic [DATAWIDTH-1:0] PAD = DATAWIDTH'(FP16_NEG_INF);
`else
    localparam logic [DATAWIDTH-1:0] PAD = DATAWIDTH'(FP16_ZERO);
`endif

    state_e                state_q, state_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [ADDRSIZE-1:0]   ptr_q, ptr_d;
    logic [WORD_W-1:0]     pack_q, pack_d;
    logic [ADDRSIZE-1:0]   end_addr_q, end_addr_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  in_ready_q, in_ready_d;
    logic                  init_q, init_d;
    logic                  start_q, start_d;

    logic                  accept_c;
    logic                  we_c;
    logic [ADDRSIZE-1:0]   waddr_c;
    logic [WORD_W-1:0]     wdata_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            ptr_q      <= BASE;
            pack_q     <= '0;
            end_addr_q <= BASE;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            init_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            ptr_q      <= ptr_d;
            pack_q     <= pack_d;
            end_addr_q <= end_addr_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
            init_q     <= init_d;
            start_q    <= start_d;
        end
    end

    // Next-state, packing and bank-write control.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        ptr_d      = ptr_q;
        pack_d     = pack_q;
        end_addr_d = end_addr_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        we_c       = 1'b0;
        waddr_c    = ptr_q;
        wdata_c    = pack_q;
        accept_c   = in_valid && in_ready_q;

        case (state_q)
            IDLE, LOAD: begin
                if (accept_c) begin
                    // First element of a new vector opens the busy window.
                    if (state_q == IDLE) begin
                        busy_d = 1'b1;
                        ovf_d  = 1'b0;
                    end
                    for (int unsigned k = 0; k < NUM; k++) begin
                        if (lane_q == LANE_W'(k)) begin
                            pack_d[k*DATAWIDTH +: DATAWIDTH] = in_data;
                        end
                    end
                    state_d = LOAD;
                    if (lane_q == LAST_LANE) begin
                        // Word complete: written the same cycle as its last element.
                        we_c       = 1'b1;
                        wdata_c    = pack_d;
                        end_addr_d = ptr_q;
                        lane_d     = '0;
                        if (in_last || (ptr_q == LAST_ADDR)) begin
                            // Top word filled without in_last: truncate here.
                            if (!in_last) begin
                                ovf_d = 1'b1;
                            end
                            ptr_d   = BASE;
                            state_d = INIT;
                        end else begin
                            ptr_d = ptr_q + ADDRSIZE'(1);
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                        if (in_last) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Lanes at or above the fill point take the pad value.
                for (int unsigned k = 0; k < NUM; k++) begin
                    if (LANE_W'(k) >= lane_q) begin
                        wdata_c[k*DATAWIDTH +: DATAWIDTH] = PAD;
                    end
                end
                we_c       = 1'b1;
                end_addr_d = ptr_q;
                lane_d     = '0;
                ptr_d      = BASE;
                state_d    = INIT;
            end
            INIT: begin
                state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Control outputs are registered from the upcoming state.
        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
        init_d     = (state_d == INIT);
        start_d    = (state_d == START);
    end

    // Three identical banks, one per softmax read port.
    softmax_rd_bank #(
        .WIDTH    (WORD_W),
        .ADDRSIZE (ADDRSIZE)
    ) u_bank_inp (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we_c),
        .waddr_i (waddr_c),
        .wdata_i (wdata_c),
        .raddr_i (addr),
        .rdata_o (inp)
    );

    softmax_rd_bank #(
        .WIDTH    (WORD_W),
        .ADDRSIZE (ADDRSIZE)
    ) u_bank_sub0 (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we_c),
        .waddr_i (waddr_c),
        .wdata_i (wdata_c),
        .raddr_i (sub0_inp_addr),
        .rdata_o (sub0_inp)
    );

    softmax_rd_bank #(
        .WIDTH    (WORD_W),
        .ADDRSIZE (ADDRSIZE)
    ) u_bank_sub1 (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we_c),
        .waddr_i (waddr_c),
        .wdata_i (wdata_c),
        .raddr_i (sub1_inp_addr),
        .rdata_o (sub1_inp)
    );

    assign in_ready   = in_ready_q;
    assign start_addr = BASE;
    assign end_addr   = end_addr_q;
    assign init       = init_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/softmax_inp_server.md
Name: softmax_inp_server

Overview:
- Memory-side responder for the softmax engine's three read ports: `addr`, `sub0_inp_addr` and `sub1_inp_addr`.
- Accepts a stream of fp16 elements and packs NUM elements per memory word.
- Stores the words in three replicated read banks and answers each softmax read address with one-cycle latency.
- Drives the softmax control inputs (`start_addr`, `end_addr`, `init`, `start`) and waits for softmax `done` before accepting a new vector.

Parameters:
- DATAWIDTH, 16, element width (SIGN+EXPONENT+MANTISSA = 1+5+10).
- NUM, 8, elements packed per memory word.
- ADDRSIZE, 7, word address width; depth is 2**ADDRSIZE words.
- BASE_ADDR, 0, first word address written and reported as `start_addr`.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream element valid.
- in_ready  out  1  stream element ready.
- in_data  in  DATAWIDTH  fp16 element.
- in_last  in  1  final element of the vector.
- addr  in  ADDRSIZE  max-stage read address from softmax.
- sub0_inp_addr  in  ADDRSIZE  first-subtractor read address.
- sub1_inp_addr  in  ADDRSIZE  second-subtractor read address.
- inp  out  DATAWIDTH*NUM  read data for `addr`.
- sub0_inp  out  DATAWIDTH*NUM  read data for `sub0_inp_addr`.
- sub1_inp  out  DATAWIDTH*NUM  read data for `sub1_inp_addr`.
- start_addr  out  ADDRSIZE  first valid word.
- end_addr  out  ADDRSIZE  last valid word.
- init  out  1  one-cycle latch-start-address pulse.
- start  out  1  one-cycle run pulse.
- done  in  1  softmax completion.
- busy  out  1  high from the first accepted element until `done` is observed.
- overflow  out  1  sticky: vector truncated at memory full.

Behaviour:
- Reset (reset=0) values:
  - State IDLE.
  - `in_ready`, `init`, `start`, `busy` and `overflow` = 0.
  - `start_addr` = BASE_ADDR, `end_addr` = BASE_ADDR.
  - `inp`, `sub0_inp`, `sub1_inp` = 0.
  - Lane counter and word pointer = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation aborts everything; a partially packed word is discarded.
- FSM states: IDLE, LOAD, FLUSH, INIT, START, WAIT.
- IDLE:
  - `in_ready` = 1.
  - First handshake (in_valid & in_ready) goes to LOAD. That element is packed and `busy` rises.
  - `overflow` clears on this first handshake.
- LOAD:
  - `in_ready` = 1.
  - Element k of a word (k = lane counter) goes in bits [k*DATAWIDTH +: DATAWIDTH].
  - When lane NUM-1 is filled, the word is written at the word pointer in all three banks (same cycle as the handshake). The lane counter then clears and the pointer increments.
  - If `in_last` arrives with lane < NUM-1, the FSM goes to FLUSH.
  - If `in_last` arrives on lane NUM-1, the word is written and the FSM goes directly to INIT.
- FLUSH:
  - One cycle, `in_ready` = 0.
  - Unfilled lanes are padded with the pad constant and the word is written.
  - Next state INIT.
- End address: `end_addr` is registered as the address of the last word written, when that word is written.
- Memory full:
  - If the word at address 2**ADDRSIZE-1 completes without `in_last`, it is treated as last.
  - `overflow` is set and the FSM goes to INIT.
  - `in_ready` stays 0 until IDLE; extra elements are back-pressured, not dropped.
- INIT: `init` = 1 for exactly one cycle, next state START.
- START: `start` = 1 for exactly one cycle, next state WAIT.
- WAIT:
  - `in_ready` = 0.
  - When `done` = 1, go to IDLE next cycle with `busy` = 0.
  - `done` seen during INIT or START is ignored.
- Reads:
  - Each bank has a registered read port: data for an address sampled at edge N is valid after edge N+1 (latency 1).
  - The three ports are fully independent; identical addresses on all ports are legal.
  - A read of the word being written in the same cycle returns the old contents (read-before-write).
  - Reads are served in every state.
- Arithmetic:
  - The word pointer is ADDRSIZE bits and never wraps; wrap is prevented by the full rule.
  - The element count is implicit: (end_addr-start_addr)*NUM + lanes.

Optional Feature:
- Macro: SOFTMAX_PAD_NEGINF_EN.
- Defined: pad lanes = 16'hFC00 (fp16 -inf), so padded lanes contribute exp()=0 and never win max.
- Undefined: pad lanes = 16'h0000 (+0.0); the caller must supply full words for correct softmax.

Decomposition:
- Package softmax_pkg holds:
  - DATAWIDTH, NUM, ADDRSIZE defaults.
  - FP16_NEG_INF = 16'hFC00 and FP16_ZERO constants.
  - State enum: IDLE, LOAD, FLUSH, INIT, START, WAIT.
- Sub-module softmax_rd_bank: one write port, one registered read port, depth 2**ADDRSIZE, width DATAWIDTH*NUM; instantiated 3x.

Test Plan:
- Full vector: 16 elements, values 1..16 as fp16, `in_last` on the 16th:
  - Word 0 lane 0 = 16'h3C00.
  - `end_addr` = 1.
  - `init` then `start` on consecutive single cycles.
  - `in_ready` = 0 until `done`.
- Partial word: 3 elements then `in_last`:
  - One FLUSH cycle.
  - Word 0 lanes 3..7 = 16'hFC00 with SOFTMAX_PAD_NEGINF_EN, 16'h0000 without.
  - `end_addr` = 0.
- Read latency: after a load, drive `addr`=0, `sub0_inp_addr`=1, `sub1_inp_addr`=0 in one cycle:
  - The next cycle shows words 0, 1, 0 on `inp`, `sub0_inp`, `sub1_inp`.
  - Reads with a changing address every cycle track at 1-cycle lag.
- Overflow: stream 1030 elements with no `in_last`:
  - 1024 accepted.
  - `in_ready` falls after the 1024th.
  - `overflow` = 1, `end_addr` = 127.
  - After `done`, the next first handshake clears `overflow`.
- Back-pressure and reset:
  - Toggle `in_valid` randomly; packing is unaffected.
  - Assert reset during LOAD lane 4: all outputs return to reset values.
  - A new 8-element vector then lands at word 0.
- Done timing: pulse `done` during START, then again 20 cycles later:
  - The first pulse is ignored.
  - IDLE is reached on the cycle after the second pulse.
